// File: rtl/cla_issue_arbiter.sv
// Round-robin issue of NUM_REQ slots onto one shared pipelined CLA adder, with a tag pipe for responses.
// Optional macro ADD_SUB_EN adds a per-slot subtract request (req_sub).
module cla_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LAT     = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
`ifdef ADD_SUB_EN
  input  logic [NUM_REQ-1:0]       req_sub,
`endif
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_vld;
  logic [WIDTH-1:0] nxt_b;
  logic             nxt_cin;
  logic [WIDTH-1:0] slot_a [NUM_REQ];
  logic [WIDTH-1:0] slot_b [NUM_REQ];
  tag_t             tag_q  [LAT];
  logic [LAT-1:0]   vld_vec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign slot_a[i] = req_a[i*WIDTH +: WIDTH];
    assign slot_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    req_ready = '0;
    if (issue_en && rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  // Operand B / carry-in as presented to the adder
  always_comb begin
    nxt_b   = slot_b[gnt_id];
    nxt_cin = req_cin[gnt_id];
`ifdef ADD_SUB_EN
    if (req_sub[gnt_id]) begin
      nxt_b   = ~slot_b[gnt_id];
      nxt_cin = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      tag_q[0] <= '0;
    end else begin
      tag_q[0].vld <= gnt_vld;
      tag_q[0].id  <= gnt_vld ? gnt_id : '0;
      if (gnt_vld) begin
        rr_ptr  <= IDW'((32'(gnt_id) + 32'd1) % NUM_REQ);
        add_a   <= slot_a[gnt_id];
        add_b   <= nxt_b;
        add_cin <= nxt_cin;
      end
    end
  end

  // Tag pipe tracks the adder latency and never stalls
  for (genvar k = 1; k < LAT; k++) begin : g_tag
    always_ff @(posedge clk) begin
      if (!rst_n) tag_q[k] <= '0;
      else        tag_q[k] <= tag_q[k-1];
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_vld
    assign vld_vec[k] = tag_q[k].vld;
  end

  assign busy      = |vld_vec;
  assign rsp_valid = tag_q[LAT-1].vld;
  assign rsp_id    = tag_q[LAT-1].id;
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;

endmodule
